// File: rtl/input_cond_pkg.sv
// Purpose: shared types and default constants for the input conditioner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: db_state_t (per-channel debounce FSM state), default
// synchronizer depth and debounce run length.
package input_cond_pkg;

  typedef enum logic {
    DB_STABLE  = 1'b0,
    DB_PENDING = 1'b1
  } db_state_t;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 16;

endpackage

// File: rtl/debounce_channel.sv
// Purpose: one raw line -> synchronizer chain -> debounce FSM -> clean level.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges from first raw sample to level.
// Backpressure: none; free-running, accepts a new raw sample every cycle.
// Ports: clk, rst_n (sync, active-low), raw (async line), level (debounced,
// registered), rise/fall (registered one-cycle pulses, only when
// INPUT_COND_EDGE_EN is defined, else tied 0), pending (FSM in PENDING).
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic pending
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_t              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q;
  logic                   flip;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flip    = 1'b0;
    case (state_q)
      DB_STABLE: begin
        cnt_d = '0;
        if (s != level_q) begin
          // A run length of one means the first differing sample is enough.
          if (DEBOUNCE_CYCLES == 1) begin
            flip = 1'b1;
          end else begin
            state_d = DB_PENDING;
            cnt_d   = CW'(1);
          end
        end
      end
      DB_PENDING: begin
        if (s == level_q) begin
          // Sample back at the old level: drop the candidate change.
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          flip    = 1'b1;
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = DB_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DB_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_q ^ flip;
    end
  end

  assign level   = level_q;
  assign pending = (state_q == DB_PENDING);

`ifdef INPUT_COND_EDGE_EN
  logic rise_q, fall_q;

  // Registered alongside level_q so the pulse lines up with the new level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= flip & ~level_q;
      fall_q <= flip &  level_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Purpose: N_IN independent synchronize+debounce channels feeding x1..x3.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges raw->level; busy one edge after state.
// Backpressure: none; all channels run in parallel every cycle, no priority.
// Ports: clk, rst_n (sync, active-low), raw_in[N_IN] (async), x_level[N_IN],
// x_rise[N_IN], x_fall[N_IN] (pulses built only with INPUT_COND_EDGE_EN,
// otherwise tied 0), busy (registered OR of per-channel PENDING).
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int N_IN            = 3,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] raw_in,
  output logic [N_IN-1:0] x_level,
  output logic [N_IN-1:0] x_rise,
  output logic [N_IN-1:0] x_fall,
  output logic            busy
);

  logic [N_IN-1:0] pending;
  logic            busy_q;

  for (genvar i = 0; i < N_IN; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw     (raw_in[i]),
      .level   (x_level[i]),
      .rise    (x_rise[i]),
      .fall    (x_fall[i]),
      .pending (pending[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= 1'b0;
    else        busy_q <= |pending;
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  localparam int N  = 3;
  localparam int SS = 2;
  localparam int DC = 4;

`ifdef INPUT_COND_EDGE_EN
  localparam logic EDGE_EN = 1'b1;
`else
  localparam logic EDGE_EN = 1'b0;
`endif

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic [N-1:0] raw_in = '0;
  logic [N-1:0] x_level, x_rise, x_fall;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0] raw;
    logic [2:0] lvl;
    logic [2:0] rise;
    logic [2:0] fall;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  input_conditioner #(
    .N_IN            (N),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_in  (raw_in),
    .x_level (x_level),
    .x_rise  (x_rise),
    .x_fall  (x_fall),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic add(input logic [2:0] r, input logic [2:0] l, input logic [2:0] ri,
                     input logic [2:0] f, input logic b);
    vec_t v;
    v.raw = r; v.lvl = l; v.rise = ri; v.fall = f; v.busy = b;
    tbl.push_back(v);
  endtask

  function automatic logic [9:0] exp_bus(input logic [2:0] l, input logic [2:0] ri,
                                         input logic [2:0] f, input logic b);
    return {l, ri & {3{EDGE_EN}}, f & {3{EDGE_EN}}, b};
  endfunction

  task automatic check(input string nm, input int idx, input logic [9:0] e);
    logic [9:0] a;
    a = {x_level, x_rise, x_fall, busy};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s[%0d]: got lvl/rise/fall/busy=%b want %b", nm, idx, a, e);
    end
  endtask

  // Drive raw away from the active edge, then sample just after the edge.
  task automatic cyc(input logic [2:0] r);
    @(negedge clk);
    raw_in = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    raw_in = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset", i, 10'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Step on ch0 at row 0: level/rise after row 5, busy rows 3..5.
    for (int i = 0; i < 3; i++) add(3'b001, 3'b000, 3'b000, 3'b000, 1'b0);
    for (int i = 0; i < 2; i++) add(3'b001, 3'b000, 3'b000, 3'b000, 1'b1);
    add(3'b001, 3'b001, 3'b001, 3'b000, 1'b1);
    for (int i = 0; i < 2; i++) add(3'b001, 3'b001, 3'b000, 3'b000, 1'b0);
    // Release ch0 at row 8: fall at row 13.
    for (int i = 0; i < 3; i++) add(3'b000, 3'b001, 3'b000, 3'b000, 1'b0);
    for (int i = 0; i < 2; i++) add(3'b000, 3'b001, 3'b000, 3'b000, 1'b1);
    add(3'b000, 3'b000, 3'b000, 3'b001, 1'b1);
    add(3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    // Three-sample glitch on ch1: one short of a full run, rejected.
    for (int i = 0; i < 3; i++) add(3'b010, 3'b000, 3'b000, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) add(3'b000, 3'b000, 3'b000, 3'b000, 1'b1);
    for (int i = 0; i < 2; i++) add(3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    // All channels step together.
    for (int i = 0; i < 3; i++) add(3'b111, 3'b000, 3'b000, 3'b000, 1'b0);
    for (int i = 0; i < 2; i++) add(3'b111, 3'b000, 3'b000, 3'b000, 1'b1);
    add(3'b111, 3'b111, 3'b111, 3'b000, 1'b1);
    for (int i = 0; i < 2; i++) add(3'b111, 3'b111, 3'b000, 3'b000, 1'b0);

    // Reset, then 50 idle cycles with everything at 0.
    do_reset();
    for (int i = 0; i < 50; i++) begin
      cyc(3'b000);
      check("idle", i, 10'd0);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].raw);
      check("table", i, exp_bus(tbl[i].lvl, tbl[i].rise, tbl[i].fall, tbl[i].busy));
    end

    // Bounce on ch2: 1,0,1,0 then held 1; release at j=21.
    do_reset();
    for (int j = 0; j < 31; j++) begin
      logic r2, l2, ri2, f2, b;
      r2  = (j < 4) ? ((j % 2) == 0) : (j < 21);
      l2  = (j >= 9) && (j < 26);
      ri2 = (j == 9);
      f2  = (j == 26);
      b   = (j == 3) || (j == 5) || (j == 7) || (j == 8) || (j == 9) ||
            (j == 24) || (j == 25) || (j == 26);
      cyc({r2, 2'b00});
      check("bounce", j, exp_bus({l2, 2'b00}, {ri2, 2'b00}, {f2, 2'b00}, b));
    end

    // Reset two cycles into PENDING with ch0 held high throughout.
    do_reset();
    for (int j = 0; j < 5; j++) begin
      cyc(3'b001);
      check("pend", j, exp_bus(3'b000, 3'b000, 3'b000, j >= 3));
    end
    @(negedge clk);
    rst_n = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(posedge clk);
      #1;
      check("midrst", j, 10'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      @(posedge clk);
      #1;
      check("postrst", j, exp_bus((j >= 6) ? 3'b001 : 3'b000,
                                  (j == 6) ? 3'b001 : 3'b000,
                                  3'b000, (j >= 4) && (j <= 6)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
